// File: rtl/systolic_lane_array_if.sv
// Byte-wide command, load/sample and drain streams of systolic_lane_array.
// master = the driving side (pin wrapper / bench), slave = the array.
interface systolic_lane_array_if #(
  parameter int WIDTH = 8
) ();
  logic [1:0]       mode;
  logic             load_start;
  logic             run_start;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             busy;

  modport master (
    output mode, load_start, run_start, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy
  );

  modport slave (
    input  mode, load_start, run_start, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/systolic_lane_array.sv
// 1-D systolic array: stationary weights, per-lane accumulators, selectable semiring.
// Optional macro SYSTOLIC_TROPICAL_EN adds min-plus/max-plus; without it modes 1x act as wrap MAC.
module systolic_lane_array #(
  parameter int WIDTH = 8,
  parameter int LANES = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  systolic_lane_array_if.slave  s_bus
);
  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0]    LAST_IDX = IW'(LANES - 1);
  localparam logic [WIDTH-1:0] ACC_MAX  = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [1:0]       r_mode;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_out_last;
  logic [WIDTH-1:0] r_out_data;
  logic             r_busy;
  logic [WIDTH-1:0] r_w   [LANES];
  logic [WIDTH-1:0] r_acc [LANES];
  logic [WIDTH-1:0] r_sx  [LANES];
  logic             r_sv  [LANES];

  state_t           w_state_nxt;
  logic [IW-1:0]    w_idx_nxt;
  logic             w_run_go;
  logic             w_accept;
  logic             w_run_accept;
  logic             w_load_accept;
  logic             w_drain_xfer;
  logic [1:0]       w_mode_eff;
  logic [WIDTH-1:0] w_identity;

  function automatic logic [1:0] f_eff_mode(input logic [1:0] m);
`ifdef SYSTOLIC_TROPICAL_EN
    return m;
`else
    return m[1] ? 2'b00 : m;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] f_op(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] acc,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] w
  );
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH:0]   sum;
    logic [WIDTH-1:0]   res;
`ifdef SYSTOLIC_TROPICAL_EN
    logic [WIDTH:0]     s_raw;
    logic [WIDTH-1:0]   s_sat;
    s_raw = {1'b0, x} + {1'b0, w};
    s_sat = s_raw[WIDTH] ? ACC_MAX : s_raw[WIDTH-1:0];
`endif
    prod = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, w};
    sum  = {1'b0, {WIDTH{1'b0}}, acc} + {1'b0, prod};
    case (m)
      2'b01:   res = (sum > {{(WIDTH+1){1'b0}}, ACC_MAX}) ? ACC_MAX : sum[WIDTH-1:0];
`ifdef SYSTOLIC_TROPICAL_EN
      2'b10:   res = (s_sat < acc) ? s_sat : acc;
      2'b11:   res = (s_sat > acc) ? s_sat : acc;
`endif
      default: res = sum[WIDTH-1:0];
    endcase
    return res;
  endfunction

  assign w_accept      = s_bus.in_valid && r_in_ready;
  assign w_run_accept  = (r_state == ST_RUN) && w_accept;
  assign w_load_accept = (r_state == ST_LOAD) && w_accept;
  assign w_drain_xfer  = r_out_valid && s_bus.out_ready;
  assign w_mode_eff    = f_eff_mode(s_bus.mode);
  assign w_identity    = (w_mode_eff == 2'b10) ? ACC_MAX : {WIDTH{1'b0}};

  // Next-state and shared index (load beat / flush count / drain lane)
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_run_go    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_bus.load_start) begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = '0;
        end else if (s_bus.run_start) begin
          w_state_nxt = ST_RUN;
          w_run_go    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (w_accept && s_bus.in_last) begin
          w_state_nxt = ST_FLUSH;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // last lane consumes the final sample on the same edge we leave FLUSH
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_DRAIN;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (w_drain_xfer) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // State register and registered outputs derived from the next state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_mode      <= 2'b00;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_mode      <= w_run_go ? w_mode_eff : r_mode;
      r_in_ready  <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RUN);
      r_out_valid <= (w_state_nxt == ST_DRAIN);
      r_out_last  <= (w_state_nxt == ST_DRAIN) && (w_idx_nxt == LAST_IDX);
      r_out_data  <= (w_state_nxt == ST_DRAIN) ? r_acc[w_idx_nxt] : '0;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Weights, sample pipe and per-lane accumulators
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        r_w[i]   <= '0;
        r_acc[i] <= '0;
        r_sx[i]  <= '0;
        r_sv[i]  <= 1'b0;
      end
    end else begin
      r_sv[0] <= w_run_accept;
      r_sx[0] <= w_run_accept ? s_bus.in_data : r_sx[0];
      for (int i = 1; i < LANES; i++) begin
        r_sv[i] <= r_sv[i-1];
        r_sx[i] <= r_sx[i-1];
      end
      for (int i = 0; i < LANES; i++) begin
        if (w_load_accept && (r_idx == IW'(i))) begin
          r_w[i] <= s_bus.in_data;
        end
        if (w_run_go) begin
          r_acc[i] <= w_identity;
        end else if (r_sv[i]) begin
          r_acc[i] <= f_op(r_mode, r_acc[i], r_sx[i], r_w[i]);
        end
      end
    end
  end

  assign s_bus.in_ready  = r_in_ready;
  assign s_bus.out_valid = r_out_valid;
  assign s_bus.out_last  = r_out_last;
  assign s_bus.out_data  = r_out_data;
  assign s_bus.busy      = r_busy;
endmodule

// File: tb/tb_systolic_lane_array.sv
// Scoreboard bench for systolic_lane_array (LANES=4, WIDTH=8); expected drains come
// from a per-lane fold of the sample list, popped by an independent drain monitor.
module tb_systolic_lane_array;
  localparam int W = 8;
  localparam int L = 4;

  typedef struct {
    int data;
    bit last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_lane_array_if #(.WIDTH(W)) bus ();

  systolic_lane_array #(.WIDTH(W), .LANES(L)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .s_bus  (bus)
  );

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    model_w[L];
  bit    bp_rand = 1'b0;
  bit    stall_armed = 1'b0;
  int    stall_left = 0;
  int    beats = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: fold each sample into one lane with the semiring rules.
  function automatic int ref_lane(input int mode, input int w, input int xs[$]);
    int m;
    int acc;
    m = mode;
`ifndef SYSTOLIC_TROPICAL_EN
    if (m >= 2) m = 0;
`endif
    acc = (m == 2) ? 255 : 0;
    foreach (xs[k]) begin
      int p;
      int s;
      p = xs[k] * w;
      s = xs[k] + w;
      if (s > 255) s = 255;
      case (m)
        0: acc = (acc + p) % 256;
        1: acc = (acc + p > 255) ? 255 : acc + p;
        2: if (s < acc) acc = s;
        default: if (s > acc) acc = s;
      endcase
    end
    return acc;
  endfunction

  // Drain monitor: owns out_ready, checks hold-while-stalled, pops the scoreboard.
  initial begin
    beat_t b;
    bit    prev_stalled;
    int    held_data;
    int    held_last;
    prev_stalled = 1'b0;
    held_data = 0;
    held_last = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bp_rand) begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end else if (stall_armed && beats == 1 && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (prev_stalled && bus.out_valid === 1'b1) begin
        check("hold_data", int'(bus.out_data), held_data);
        check("hold_last", int'(bus.out_last), held_last);
      end
      prev_stalled = (bus.out_valid === 1'b1) && !bus.out_ready;
      held_data = int'(bus.out_data);
      held_last = int'(bus.out_last);
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", int'(bus.out_data), -1);
        end else begin
          b = exp_q.pop_front();
          check("drain_data", int'(bus.out_data), b.data);
          check("drain_last", int'(bus.out_last), int'(b.last));
        end
        beats++;
      end
    end
  end

  task automatic pulse_cmd(input bit ld, input bit rn);
    bus.load_start = ld;
    bus.run_start  = rn;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    bus.run_start  = 1'b0;
  endtask

  task automatic send_beat(input int d, input bit last);
    int guard;
    guard = 0;
    bus.in_data  = 8'(d);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic load_weights(input int ws[L]);
    pulse_cmd(1'b1, 1'b0);
    for (int i = 0; i < L; i++) send_beat(ws[i], 1'b0);
    model_w = ws;
    @(negedge clk);
    check("load_busy_low", int'(bus.busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.busy !== 1'b0) && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    check("drain_done", (guard < 300) ? 1 : 0, 1);
    @(posedge clk); #1;
  endtask

  // gap < 0 picks a random 0..2 cycle bubble between samples
  task automatic do_run(input int mode, input int xs[$], input int gap, input bit stall);
    beat_t b;
    int    g;
    for (int i = 0; i < L; i++) begin
      b.data = ref_lane(mode, model_w[i], xs);
      b.last = (i == L - 1);
      exp_q.push_back(b);
    end
    beats = 0;
    stall_left = 3;
    stall_armed = stall;
    bus.mode = 2'(mode);
    pulse_cmd(1'b0, 1'b1);
    foreach (xs[k]) begin
      send_beat(xs[k], k == xs.size() - 1);
      g = (gap >= 0) ? gap : int'($urandom_range(0, 2));
      if (g > 0 && k < xs.size() - 1) begin
        repeat (g) @(posedge clk);
        #1;
      end
    end
    wait_done();
    stall_armed = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int ws[L];
    int xs[$];
    bus.mode       = 2'b00;
    bus.load_start = 1'b0;
    bus.run_start  = 1'b0;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_weights('{1, 2, 3, 4});
    do_run(0, '{1, 2, 3}, 0, 1'b0);

    load_weights('{200, 200, 200, 200});
    do_run(1, '{2, 2}, 0, 1'b0);
    do_run(0, '{2, 2}, 0, 1'b0);

    load_weights('{10, 20, 30, 40});
    do_run(2, '{5, 3, 250}, 0, 1'b0);
    do_run(3, '{5, 3, 250}, 0, 1'b0);

    load_weights('{1, 2, 3, 4});
    do_run(0, '{1, 2, 3}, 2, 1'b1);

    // abandon a run with a one-cycle reset after the second sample
    bus.mode = 2'b00;
    pulse_cmd(1'b0, 1'b1);
    send_beat(1, 1'b0);
    send_beat(2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    for (int i = 0; i < L; i++) model_w[i] = 0;
    do_run(0, '{7, 9}, 0, 1'b0);

    // load wins over a simultaneous run; run_start inside LOAD is ignored
    bus.mode = 2'b00;
    pulse_cmd(1'b1, 1'b1);
    @(negedge clk);
    check("coll_busy", int'(bus.busy), 1);
    check("coll_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    pulse_cmd(1'b0, 1'b1);
    for (int i = 0; i < L; i++) send_beat(5 + i, 1'b0);
    model_w = '{5, 6, 7, 8};
    @(negedge clk);
    check("coll_idle_after_load", int'(bus.busy), 0);
    @(posedge clk); #1;
    do_run(0, '{3, 1}, 0, 1'b0);

    bp_rand = 1'b1;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < L; i++) ws[i] = int'($urandom_range(0, 255));
      load_weights(ws);
      xs.delete();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) xs.push_back(int'($urandom_range(0, 255)));
      do_run(int'($urandom_range(0, 3)), xs, -1, 1'b0);
    end
    bp_rand = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
